// File: rtl/logic_analyzer_controller.sv
// Logic analyzer control/status register window merged with the capture state machine.
// Bus path: one register stage (addr/data/rw/valid in -> out); write strobe follows trig_i combinationally.
// No backpressure: the bus is a fixed-latency daisy chain; the sample memory accepts one write per cycle.
module logic_analyzer_controller #(
  parameter int BASE_ADDR    = 0,
  parameter int SAMPLE_DEPTH = 1024,
  parameter int ADDR_WIDTH   = $clog2(SAMPLE_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           addr_i,
  input  logic [15:0]           data_i,
  input  logic                  rw_i,
  input  logic                  valid_i,
  output logic [15:0]           addr_o,
  output logic [15:0]           data_o,
  output logic                  rw_o,
  output logic                  valid_o,
  input  logic                  trig_i,
  output logic [3:0]            state_o,
  output logic                  write_enable_o,
  output logic [ADDR_WIDTH-1:0] write_pointer_o,
  output logic [ADDR_WIDTH-1:0] read_pointer_o
);

  typedef enum logic [3:0] {
    IDLE             = 4'd0,
    MOVE_TO_POSITION = 4'd1,
    IN_POSITION      = 4'd2,
    CAPTURING        = 4'd3,
    CAPTURED         = 4'd4
  } state_t;

  localparam logic [1:0]            MODE_SINGLE = 2'd0;
  localparam logic [1:0]            MODE_INCR   = 2'd1;
  localparam logic [15:0]           BASE        = 16'(BASE_ADDR);
  localparam logic [15:0]           LOC_MAX16   = 16'(SAMPLE_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LOC_MAX     = ADDR_WIDTH'(SAMPLE_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE     = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE     = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL    = (ADDR_WIDTH + 1)'(SAMPLE_DEPTH);

  state_t                state;
  logic [1:0]            trigger_mode;
  logic [ADDR_WIDTH-1:0] trigger_loc;
  logic                  request_start;
  logic                  request_stop;
  logic                  start_prev;
  logic                  stop_prev;
  logic                  capture_en;
  logic [ADDR_WIDTH-1:0] wp;
  logic [ADDR_WIDTH-1:0] rp;
  logic [ADDR_WIDTH:0]   count;

  logic [16:0] diff;
  logic        hit;
  logic [15:0] rdata;
  logic        start_evt;
  logic        stop_evt;

  // 17-bit subtraction keeps addresses below BASE from aliasing into the window
  assign diff = {1'b0, addr_i} - {1'b0, BASE};
  assign hit  = valid_i && !diff[16] && (diff[15:0] < 16'd7);

  assign start_evt = request_start && !start_prev;
  assign stop_evt  = request_stop && !stop_prev;

  // Incremental capture writes only on trigger cycles, so the strobe follows trig_i directly
  assign write_enable_o = capture_en && !stop_evt &&
                          ((state != CAPTURING) || (trigger_mode != MODE_INCR) || trig_i);

  assign state_o         = 4'(state);
  assign write_pointer_o = wp;
  assign read_pointer_o  = rp;

  // Register readback mux, zero-extended to the bus width
  always_comb begin
    rdata = 16'd0;
    case (diff[2:0])
      3'd0:    rdata = 16'(state);
      3'd1:    rdata = 16'(trigger_mode);
      3'd2:    rdata = 16'(trigger_loc);
      3'd3:    rdata = 16'(request_start);
      3'd4:    rdata = 16'(request_stop);
      3'd5:    rdata = 16'(rp);
      3'd6:    rdata = 16'(wp);
      default: rdata = 16'd0;
    endcase
  end

  // Bus pipeline stage: pass everything through, substitute read data on a read hit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_o  <= 16'd0;
      data_o  <= 16'd0;
      rw_o    <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      addr_o  <= addr_i;
      rw_o    <= rw_i;
      valid_o <= valid_i;
      data_o  <= (hit && !rw_i) ? rdata : data_i;
    end
  end

  // Control register writes; configuration is locked once a capture is armed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trigger_mode  <= 2'd0;
      trigger_loc   <= '0;
      request_start <= 1'b0;
      request_stop  <= 1'b0;
      start_prev    <= 1'b0;
      stop_prev     <= 1'b0;
    end else begin
      start_prev <= request_start;
      stop_prev  <= request_stop;
      if (hit && rw_i) begin
        case (diff[2:0])
          3'd1: if (state == IDLE) trigger_mode <= data_i[1:0];
          3'd2: if (state == IDLE) trigger_loc <= (data_i > LOC_MAX16) ? LOC_MAX : data_i[ADDR_WIDTH-1:0];
          3'd3: request_start <= data_i[0];
          3'd4: request_stop  <= data_i[0];
          default: ;
        endcase
      end
    end
  end

  // Capture state machine: pre-trigger fill, trigger wait, post-trigger fill, freeze
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      capture_en <= 1'b0;
      wp         <= '0;
      rp         <= '0;
      count      <= '0;
    end else if (stop_evt) begin
      state      <= IDLE;
      capture_en <= 1'b0;
      wp         <= '0;
      rp         <= '0;
      count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          wp         <= '0;
          rp         <= '0;
          count      <= '0;
          capture_en <= 1'b0;
          if (start_evt) begin
            capture_en <= 1'b1;
            if (trigger_mode == MODE_SINGLE)
              state <= (trigger_loc == '0) ? IN_POSITION : MOVE_TO_POSITION;
            else
              state <= CAPTURING;
          end
        end
        MOVE_TO_POSITION: begin
          wp <= wp + PTR_ONE;
          if (wp == trigger_loc - PTR_ONE) state <= IN_POSITION;
        end
        IN_POSITION: begin
          wp <= wp + PTR_ONE;
          if (trig_i) begin
            // Keep trigger_loc samples before the trigger sample itself
            rp    <= wp - trigger_loc;
            count <= {1'b0, trigger_loc} + CNT_ONE;
            if (trigger_loc == LOC_MAX) begin
              state      <= CAPTURED;
              capture_en <= 1'b0;
            end else begin
              state <= CAPTURING;
            end
          end else begin
            rp <= wp + PTR_ONE - trigger_loc;
          end
        end
        CAPTURING: begin
          if (write_enable_o) begin
            wp    <= wp + PTR_ONE;
            count <= count + CNT_ONE;
            if (count + CNT_ONE == CNT_FULL) begin
              state      <= CAPTURED;
              capture_en <= 1'b0;
            end
          end
        end
        CAPTURED: capture_en <= 1'b0;
        default: begin
          state      <= IDLE;
          capture_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_analyzer_controller.sv
// Bench for logic_analyzer_controller at SAMPLE_DEPTH=8, BASE_ADDR=0x10.
module tb_logic_analyzer_controller;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   addr_i, data_i, addr_o, data_o;
  logic          rw_i, valid_i, rw_o, valid_o, trig_i;
  logic [3:0]    state_o;
  logic          write_enable_o;
  logic [AW-1:0] write_pointer_o, read_pointer_o;

  int total = 0;
  int bad   = 0;

  logic_analyzer_controller #(.BASE_ADDR(16'h10), .SAMPLE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .addr_i(addr_i), .data_i(data_i), .rw_i(rw_i), .valid_i(valid_i),
    .addr_o(addr_o), .data_o(data_o), .rw_o(rw_o), .valid_o(valid_o),
    .trig_i(trig_i), .state_o(state_o), .write_enable_o(write_enable_o),
    .write_pointer_o(write_pointer_o), .read_pointer_o(read_pointer_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] q;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_xfer(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic v, output logic [15:0] q);
    addr_i  = a;
    data_i  = d;
    rw_i    = w;
    valid_i = v;
    tick;
    q       = data_o;
    valid_i = 1'b0;
    rw_i    = 1'b0;
  endtask

  task automatic arm(input int mode, input int tl);
    logic [15:0] q;
    bus_xfer(1'b1, 16'h14, 16'd1, 1'b1, q);
    bus_xfer(1'b1, 16'h14, 16'd0, 1'b1, q);
    bus_xfer(1'b1, 16'h13, 16'd0, 1'b1, q);
    bus_xfer(1'b1, 16'h11, 16'(mode), 1'b1, q);
    bus_xfer(1'b1, 16'h12, 16'(tl), 1'b1, q);
    bus_xfer(1'b1, 16'h13, 16'd1, 1'b1, q);
  endtask

  // Expected write list is derived from the capture rules directly:
  // single shot writes every cycle from start until DEPTH-tl-1 cycles after the first
  // trigger seen at cycle >= tl; incremental writes on the first DEPTH trigger cycles;
  // immediate writes DEPTH consecutive cycles. Address of the n-th write is n mod DEPTH.
  task automatic run_capture(input int mode, input int tl, input logic [127:0] pat, input string tag);
    int obs_k[$];
    int obs_a[$];
    int exp_k[$];
    int exp_a[$];
    int rp_exp;
    int t;
    logic done;
    logic [15:0] q;
    rp_exp = 0;
    if (mode == 0) begin
      t = -1;
      for (int k = tl; k < 128; k++)
        if (t < 0 && pat[k]) t = k;
      for (int k = 0; k < t + DEPTH - tl; k++) begin
        exp_k.push_back(k);
        exp_a.push_back(k % DEPTH);
      end
      rp_exp = (t - tl) % DEPTH;
    end else if (mode == 1) begin
      for (int k = 0; k < 128; k++)
        if (pat[k] && exp_k.size() < DEPTH) begin
          exp_a.push_back(exp_k.size());
          exp_k.push_back(k);
        end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        exp_k.push_back(k);
        exp_a.push_back(k);
      end
    end

    arm(mode, tl);
    tick;
    done = 1'b0;
    for (int k = 0; k < 128 && !done; k++) begin
      if (state_o == 4'd4) begin
        done = 1'b1;
      end else begin
        trig_i = pat[k];
        #1;
        if (write_enable_o) begin
          obs_k.push_back(k);
          obs_a.push_back(int'(write_pointer_o));
        end
        tick;
      end
    end
    trig_i = 1'b0;

    chk({tag, "_captured_state"}, int'(state_o), 4);
    chk({tag, "_write_count"}, obs_k.size(), exp_k.size());
    for (int i = 0; i < exp_k.size() && i < obs_k.size(); i++) begin
      chk($sformatf("%s_write%0d_cycle", tag, i), obs_k[i], exp_k[i]);
      chk($sformatf("%s_write%0d_addr", tag, i), obs_a[i], exp_a[i]);
    end
    chk({tag, "_we_after"}, int'(write_enable_o), 0);
    chk({tag, "_rp"}, int'(read_pointer_o), rp_exp);
    chk({tag, "_wp"}, int'(write_pointer_o), rp_exp);
    bus_xfer(1'b0, 16'h15, 16'd0, 1'b1, q);
    chk({tag, "_rd_rp"}, int'(q), rp_exp);
    bus_xfer(1'b0, 16'h16, 16'd0, 1'b1, q);
    chk({tag, "_rd_wp"}, int'(q), rp_exp);
    bus_xfer(1'b0, 16'h10, 16'd0, 1'b1, q);
    chk({tag, "_rd_state"}, int'(q), 4);
  endtask

  initial begin
    logic [15:0]  q;
    logic [127:0] pat;
    int mode;
    int tl;

    tbl[0]  = '{1'b1, 1'b0, 16'h10, 16'h1111, 16'h0000};
    tbl[1]  = '{1'b1, 1'b1, 16'h11, 16'h0002, 16'h0002};
    tbl[2]  = '{1'b1, 1'b0, 16'h11, 16'hFFFF, 16'h0002};
    tbl[3]  = '{1'b1, 1'b1, 16'h12, 16'd100,  16'd100};
    tbl[4]  = '{1'b1, 1'b0, 16'h12, 16'h0000, 16'h0007};
    tbl[5]  = '{1'b1, 1'b1, 16'h12, 16'h0005, 16'h0005};
    tbl[6]  = '{1'b1, 1'b0, 16'h12, 16'h0000, 16'h0005};
    tbl[7]  = '{1'b1, 1'b1, 16'h11, 16'hFFFF, 16'hFFFF};
    tbl[8]  = '{1'b1, 1'b0, 16'h11, 16'h0000, 16'h0003};
    tbl[9]  = '{1'b1, 1'b0, 16'h20, 16'hABCD, 16'hABCD};
    tbl[10] = '{1'b1, 1'b1, 16'h17, 16'h1234, 16'h1234};
    tbl[11] = '{1'b1, 1'b1, 16'h10, 16'h0009, 16'h0009};
    tbl[12] = '{1'b1, 1'b0, 16'h10, 16'h0000, 16'h0000};
    tbl[13] = '{1'b1, 1'b1, 16'h15, 16'h0003, 16'h0003};
    tbl[14] = '{1'b1, 1'b0, 16'h15, 16'h0000, 16'h0000};
    tbl[15] = '{1'b1, 1'b0, 16'h0F, 16'h5555, 16'h5555};
    tbl[16] = '{1'b0, 1'b0, 16'h11, 16'h7777, 16'h7777};
    tbl[17] = '{1'b1, 1'b0, 16'h13, 16'h0000, 16'h0000};
    tbl[18] = '{1'b1, 1'b1, 16'h12, 16'h8000, 16'h8000};
    tbl[19] = '{1'b1, 1'b0, 16'h12, 16'h0000, 16'h0007};

    rst = 1'b1; addr_i = '0; data_i = '0; rw_i = 1'b0; valid_i = 1'b0; trig_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", int'(state_o), 0);
    chk("reset_we", int'(write_enable_o), 0);
    chk("reset_wp", int'(write_pointer_o), 0);
    chk("reset_rp", int'(read_pointer_o), 0);
    chk("reset_bus", int'({addr_o, data_o}), 0);
    chk("reset_bus_ctl", int'({rw_o, valid_o}), 0);
    rst = 1'b0;
    tick;

    // Register map and pass-through vectors
    for (int i = 0; i < 20; i++) begin
      bus_xfer(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].v, q);
      chk($sformatf("vec%0d_data", i), int'(q), int'(tbl[i].q));
      chk($sformatf("vec%0d_addr", i), int'(addr_o), int'(tbl[i].a));
      chk($sformatf("vec%0d_ctl", i), int'({rw_o, valid_o}), int'({tbl[i].w, tbl[i].v}));
    end

    // Immediate capture, single shot with pre-trigger, incremental on alternate cycles
    run_capture(2, 0, 128'd0, "imm");
    pat = 128'd1 << 13;
    run_capture(0, 3, pat, "single");
    chk("single_rp_fixed", int'(read_pointer_o), 2);
    pat = {32{4'hA}};
    run_capture(1, 0, pat, "incr");

    // Configuration locked while capturing
    arm(1, 0);
    tick;
    bus_xfer(1'b1, 16'h11, 16'd2, 1'b1, q);
    bus_xfer(1'b0, 16'h11, 16'd0, 1'b1, q);
    chk("lock_mode", int'(q), 1);
    bus_xfer(1'b0, 16'h10, 16'd0, 1'b1, q);
    chk("lock_state", int'(q), 3);
    bus_xfer(1'b1, 16'h12, 16'd4, 1'b1, q);
    bus_xfer(1'b0, 16'h12, 16'd0, 1'b1, q);
    chk("lock_loc", int'(q), 0);

    // Stop while waiting for trigger, with a coincident trigger
    arm(0, 3);
    repeat (6) tick;
    chk("stop_pre_state", int'(state_o), 2);
    bus_xfer(1'b1, 16'h14, 16'd1, 1'b1, q);
    trig_i = 1'b1;
    tick;
    chk("stop_state", int'(state_o), 0);
    chk("stop_wp", int'(write_pointer_o), 0);
    chk("stop_rp", int'(read_pointer_o), 0);
    chk("stop_we", int'(write_enable_o), 0);
    trig_i = 1'b0;

    // Randomized capture sessions
    for (int n = 0; n < 12; n++) begin
      mode = int'($urandom_range(0, 3));
      tl   = int'($urandom_range(0, DEPTH - 1));
      pat  = '1;
      for (int b = 0; b < 60; b++) pat[b] = ($urandom_range(0, 2) == 0);
      run_capture(mode, tl, pat, $sformatf("rnd%0d_m%0d_t%0d", n, mode, tl));
    end

    // Asynchronous reset in the middle of a capture
    arm(2, 0);
    repeat (3) tick;
    chk("pre_rst_state", int'(state_o), 3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", int'(state_o), 0);
    chk("arst_we", int'(write_enable_o), 0);
    chk("arst_ptrs", int'({write_pointer_o, read_pointer_o}), 0);
    chk("arst_bus", int'({addr_o, data_o}), 0);
    chk("arst_bus_ctl", int'({rw_o, valid_o}), 0);
    #1;
    rst = 1'b0;
    tick;
    bus_xfer(1'b0, 16'h11, 16'd0, 1'b1, q);
    chk("arst_rd_mode", int'(q), 0);
    bus_xfer(1'b0, 16'h12, 16'd0, 1'b1, q);
    chk("arst_rd_loc", int'(q), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
